regfile_write_sequencer: RTL and testbench
==========================================

# regfile_write_sequencer

Write-port controller for the 32×32 register file. It shares the single register-file write port between three writeback requesters (ALU, load unit, multiply/divide unit) using round-robin arbitration with a valid/ready handshake. It also sequences a hardware clear of registers 1..31 after reset and on request. It sits between the writeback stage and the register file's `WriteAddr`/`WriteData`/`RegWrite` inputs.

## Interface
- `NUM_REQ`, 3, number of writeback requesters; index 0 = ALU, 1 = load, 2 = mul/div
- `ADDR_W`, 5, register address width
- `DATA_W`, 32, register data width

Ports:
- `Clock`  in  1  single clock; all state changes on its rising edge
- `Reset`  in  1  asynchronous, active-high reset
- `ReqValid`  in  NUM_REQ  requester i has a write pending
- `ReqAddr`  in  NUM_REQ*ADDR_W  flattened; requester i at bits [i*ADDR_W +: ADDR_W]
- `ReqData`  in  NUM_REQ*DATA_W  flattened; requester i at bits [i*DATA_W +: DATA_W]
- `ReqReady`  out  NUM_REQ  one-hot or zero; the write is accepted this cycle
- `ClearReq`  in  1  single-cycle pulse requesting a full register clear
- `WriteAddr`  out  ADDR_W  registered; drives the register-file write address
- `WriteData`  out  DATA_W  registered; drives the register-file write data
- `RegWrite`  out  1  registered; drives the register-file write enable
- `Busy`  out  1  high while a clear sequence is in progress

## Operation
- FSM states are `ST_CLEAR` and `ST_RUN`. There is a clear counter `clr_cnt` (5 bits) and a round-robin pointer `last`, which holds the index of the last granted requester.
- Reset values: state `ST_CLEAR`, `clr_cnt`=1, `last`=NUM_REQ-1, `RegWrite`=0, `WriteAddr`=0, `WriteData`=0. `Busy`=1 and `ReqReady`=0 follow from the state.
- `ST_CLEAR`, on each edge:
  - outputs load `WriteAddr`=`clr_cnt`, `WriteData`=0, `RegWrite`=1;
  - if `clr_cnt`==31, go to `ST_RUN`; otherwise increment `clr_cnt`.
  - `ReqReady` is all zero throughout.
  - `ClearReq` is ignored.
- `ST_RUN`:
  - `Busy`=0.
  - If `ClearReq`=1: `ReqReady`=0, and at the next edge `clr_cnt`←1, state←`ST_CLEAR`, `RegWrite`←0.
  - Otherwise the grant is the first i with `ReqValid[i]`=1, searching cyclically from `last`+1 (mod NUM_REQ). `ReqReady[grant]`=1; this is combinational from `ReqValid`, `last` and state.
- Handshake: a transfer occurs when `ReqValid[i]` and `ReqReady[i]` are both 1.
  - On that edge: `last`←i, `WriteAddr`←`ReqAddr[i]`, `WriteData`←`ReqData[i]`, `RegWrite`←(`ReqAddr[i]`≠0).
  - With no transfer: `RegWrite`←0, `WriteAddr`/`WriteData` hold.
- Requesters must hold Valid, Addr and Data stable until accepted, and must not retract Valid. The controller accepts at most one write per cycle.
- Writes to address 0 complete the handshake normally, but `RegWrite` stays 0. Register 0 is never written, and the clear sequence never touches it.

## Timing
- Write latency: a handshake at edge N makes `RegWrite`/`WriteAddr`/`WriteData` valid in the cycle after edge N. The register file captures the write at edge N+1.
- Clear sequence:
  - exactly 31 consecutive `RegWrite` cycles, addresses 1,2,…,31, data 0;
  - `Busy` falls after the 31st clear edge;
  - the first `ReqReady` can assert in that same cycle.
- `ClearReq` in `ST_RUN` takes effect with no accepted write in that cycle. The first clear write (address 1) appears after the second edge following the pulse.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,0,… One write per cycle, no starvation; worst-case wait is NUM_REQ-1 cycles.
- Simultaneous `ClearReq` and `ReqValid`: the clear wins; requests wait until `ST_RUN` resumes. The pointer `last` is unchanged by a clear.
- Reset mid-operation:
  - all outputs go to their reset values immediately (asynchronous);
  - `ReqReady` drops;
  - after release, the clear restarts at address 1.

## Structure
- Shared package `regfile_pkg`:
  - `ADDR_W`=5, `DATA_W`=32, `NUM_REGS`=32, `LAST_REG`=31;
  - `typedef enum {ST_CLEAR, ST_RUN} wseq_state_t`.
- Sub-module `rr_arbiter`:
  - parameter `NUM_REQ`;
  - inputs: request vector, `last` pointer, enable;
  - output: one-hot grant;
  - purely combinational.
- Pointer update and the output registers stay in `regfile_write_sequencer`.

## Test plan
- Release `Reset` with no requests → `RegWrite`=1 for 31 consecutive cycles, `WriteAddr` 1..31, `WriteData`=0; `Busy`=1 throughout, then 0; `ReqReady`=0 during the clear.
- After the clear, req1 valid with addr 5, data 0xDEADBEEF → `ReqReady`=3'b010 the same cycle; the next cycle shows `RegWrite`=1, `WriteAddr`=5, `WriteData`=0xDEADBEEF.
- All three requesters held valid (addrs 1/2/3, data 0xA/0xB/0xC) → grants 0,1,2,0,1,2; `RegWrite` high every cycle with matching addr/data.
- req2 valid with addr 0, data 0xFFFFFFFF → handshake completes; `RegWrite` stays 0 the next cycle.
- `ClearReq` pulse while req0 is valid (addr 7) → `ReqReady`=0; 31 clear writes follow; req0's write to 7 occurs first after `Busy` falls.
- Assert `Reset` when the clear is at address 12 → `RegWrite`/`WriteAddr`/`WriteData` go to 0 before the next edge; after release, the clear restarts at address 1 and runs the full 31 cycles.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write path: geometry constants
// and the write-sequencer state encoding.
package regfile_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int LAST_REG = 31;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } wseq_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found when
// searching cyclically from the one after the last winner.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   last_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] grant_o
);

    logic             found;
    logic [PTR_W-1:0] idx;

    // Offset k=NUM_REQ wraps back to the last winner itself, so it still wins
    // when it is the only requester.
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = PTR_W'((int'(last_i) + k) % NUM_REQ);
            if (en_i && !found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_write_sequencer.sv
// Register-file write-port controller: round-robin arbitration between the
// writeback requesters plus a hardware clear of registers 1..31.
module regfile_write_sequencer #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        ReqValid,
    input  logic [NUM_REQ*ADDR_W-1:0] ReqAddr,
    input  logic [NUM_REQ*DATA_W-1:0] ReqData,
    output logic [NUM_REQ-1:0]        ReqReady,
    input  logic                      ClearReq,
    output logic [ADDR_W-1:0]         WriteAddr,
    output logic [DATA_W-1:0]         WriteData,
    output logic                      RegWrite,
    output logic                      Busy
);

    import regfile_pkg::*;

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    wseq_state_t          state_q, state_d;
    logic [ADDR_W-1:0]    clr_cnt_q, clr_cnt_d;
    logic [PTR_W-1:0]     last_q, last_d;
    logic [ADDR_W-1:0]    waddr_q, waddr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic                 regwrite_q, regwrite_d;
    logic                 arb_en;
    logic [NUM_REQ-1:0]   grant;

    assign arb_en = (state_q == ST_RUN) && !ClearReq;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req_i   (ReqValid),
        .last_i  (last_q),
        .en_i    (arb_en),
        .grant_o (grant)
    );

    assign ReqReady  = grant;
    assign Busy      = (state_q == ST_CLEAR);
    assign WriteAddr = waddr_q;
    assign WriteData = wdata_q;
    assign RegWrite  = regwrite_q;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_CLEAR;
            clr_cnt_q  <= ADDR_W'(1);
            last_q     <= PTR_W'(NUM_REQ - 1);
            waddr_q    <= '0;
            wdata_q    <= '0;
            regwrite_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            last_q     <= last_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            regwrite_q <= regwrite_d;
        end
    end

    // Grants are only ever raised on valid requesters, so a set grant bit is
    // exactly a completed handshake. Address 0 handshakes but never writes.
    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        last_d     = last_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        regwrite_d = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                waddr_d    = clr_cnt_q;
                wdata_d    = '0;
                regwrite_d = 1'b1;
                if (clr_cnt_q == ADDR_W'(LAST_REG)) begin
                    state_d = ST_RUN;
                end else begin
                    clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                end
            end
            ST_RUN: begin
                if (ClearReq) begin
                    clr_cnt_d = ADDR_W'(1);
                    state_d   = ST_CLEAR;
                end else begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (grant[i]) begin
                            last_d     = PTR_W'(i);
                            waddr_d    = ReqAddr[i*ADDR_W +: ADDR_W];
                            wdata_d    = ReqData[i*DATA_W +: DATA_W];
                            regwrite_d = (ReqAddr[i*ADDR_W +: ADDR_W] != '0);
                        end
                    end
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Directed self-checking bench for regfile_write_sequencer: clear sequence,
// arbitration rotation, address-0 suppression, clear request and mid-clear reset.
module tb_regfile_write_sequencer;

    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 32;

    logic                      Clock;
    logic                      Reset;
    logic [NUM_REQ-1:0]        ReqValid;
    logic [NUM_REQ*ADDR_W-1:0] ReqAddr;
    logic [NUM_REQ*DATA_W-1:0] ReqData;
    logic [NUM_REQ-1:0]        ReqReady;
    logic                      ClearReq;
    logic [ADDR_W-1:0]         WriteAddr;
    logic [DATA_W-1:0]         WriteData;
    logic                      RegWrite;
    logic                      Busy;

    int checks = 0;
    int errors = 0;

    regfile_write_sequencer #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .ReqValid  (ReqValid),
        .ReqAddr   (ReqAddr),
        .ReqData   (ReqData),
        .ReqReady  (ReqReady),
        .ClearReq  (ClearReq),
        .WriteAddr (WriteAddr),
        .WriteData (WriteData),
        .RegWrite  (RegWrite),
        .Busy      (Busy)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] valid, input logic [14:0] addrs,
                                 input logic [95:0] datas, input logic clr);
        ReqValid = valid;
        ReqAddr  = addrs;
        ReqData  = datas;
        ClearReq = clr;
    endtask

    task automatic nextCycle();
        @(posedge Clock);
        #1;
    endtask

    // Expects the clear to be entered on the next edge; checks all 31 writes.
    task automatic checkClearRun(input string tag, input logic [2:0] readyAfter);
        for (int k = 1; k <= 31; k++) begin
            nextCycle();
            #1;
            checkOutput({tag, "_regwrite"}, 32'(RegWrite), 32'd1);
            checkOutput({tag, "_addr"}, 32'(WriteAddr), 32'(k));
            checkOutput({tag, "_data"}, WriteData, 32'd0);
            checkOutput({tag, "_busy"}, 32'(Busy), (k < 31) ? 32'd1 : 32'd0);
            checkOutput({tag, "_ready"}, 32'(ReqReady), (k < 31) ? 32'd0 : 32'(readyAfter));
        end
    endtask

    logic [2:0]  rotGrant [6];
    logic [31:0] addr;

    initial begin
        Reset = 1'b0;
        applyStimulus(3'b000, '0, '0, 1'b0);
        #2 Reset = 1'b1;
        nextCycle();
        nextCycle();
        checkOutput("rst_regwrite", 32'(RegWrite), 32'd0);
        checkOutput("rst_addr", 32'(WriteAddr), 32'd0);
        checkOutput("rst_data", WriteData, 32'd0);
        checkOutput("rst_busy", 32'(Busy), 32'd1);
        checkOutput("rst_ready", 32'(ReqReady), 32'd0);
        Reset = 1'b0;
        checkClearRun("clear0", 3'b000);

        // Single request from the load unit.
        applyStimulus(3'b010, {5'd0, 5'd5, 5'd0}, {32'd0, 32'hDEADBEEF, 32'd0}, 1'b0);
        #1;
        checkOutput("req1_ready", 32'(ReqReady), 32'b010);
        nextCycle();
        applyStimulus(3'b000, '0, '0, 1'b0);
        #1;
        checkOutput("req1_regwrite", 32'(RegWrite), 32'd1);
        checkOutput("req1_addr", 32'(WriteAddr), 32'd5);
        checkOutput("req1_data", WriteData, 32'hDEADBEEF);
        checkOutput("req1_idle_ready", 32'(ReqReady), 32'd0);

        // Last winner was 1, so rotation continues at 2.
        rotGrant = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
        applyStimulus(3'b111, {5'd3, 5'd2, 5'd1}, {32'hC, 32'hB, 32'hA}, 1'b0);
        for (int n = 0; n < 6; n++) begin
            #1;
            checkOutput("rot_ready", 32'(ReqReady), 32'(rotGrant[n]));
            nextCycle();
            addr = (rotGrant[n] == 3'b001) ? 32'd1 : (rotGrant[n] == 3'b010) ? 32'd2 : 32'd3;
            checkOutput("rot_regwrite", 32'(RegWrite), 32'd1);
            checkOutput("rot_addr", 32'(WriteAddr), addr);
            checkOutput("rot_data", WriteData, addr + 32'h9);
        end
        applyStimulus(3'b000, '0, '0, 1'b0);

        // Address 0 handshakes but must not write.
        applyStimulus(3'b100, {5'd0, 5'd0, 5'd0}, {32'hFFFFFFFF, 32'd0, 32'd0}, 1'b0);
        #1;
        checkOutput("zero_ready", 32'(ReqReady), 32'b100);
        nextCycle();
        applyStimulus(3'b000, '0, '0, 1'b0);
        #1;
        checkOutput("zero_regwrite", 32'(RegWrite), 32'd0);
        checkOutput("zero_data", WriteData, 32'hFFFFFFFF);

        // Clear request beats a pending write from the ALU.
        applyStimulus(3'b001, {5'd0, 5'd0, 5'd7}, {32'd0, 32'd0, 32'h77}, 1'b1);
        #1;
        checkOutput("clrreq_ready", 32'(ReqReady), 32'd0);
        checkOutput("clrreq_busy", 32'(Busy), 32'd0);
        nextCycle();
        ClearReq = 1'b0;
        #1;
        checkOutput("clrreq_regwrite", 32'(RegWrite), 32'd0);
        checkOutput("clrreq_busy_hi", 32'(Busy), 32'd1);
        checkOutput("clrreq_ready_hold", 32'(ReqReady), 32'd0);
        checkClearRun("clear1", 3'b001);
        nextCycle();
        applyStimulus(3'b000, '0, '0, 1'b0);
        #1;
        checkOutput("pend_regwrite", 32'(RegWrite), 32'd1);
        checkOutput("pend_addr", 32'(WriteAddr), 32'd7);
        checkOutput("pend_data", WriteData, 32'h77);

        // Reset partway through a clear.
        ClearReq = 1'b1;
        nextCycle();
        ClearReq = 1'b0;
        for (int k = 1; k <= 12; k++) nextCycle();
        checkOutput("mid_addr12", 32'(WriteAddr), 32'd12);
        Reset = 1'b1;
        #1;
        checkOutput("mid_rst_regwrite", 32'(RegWrite), 32'd0);
        checkOutput("mid_rst_addr", 32'(WriteAddr), 32'd0);
        checkOutput("mid_rst_data", WriteData, 32'd0);
        checkOutput("mid_rst_busy", 32'(Busy), 32'd1);
        nextCycle();
        Reset = 1'b0;
        checkClearRun("clear2", 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
